// File: rtl/gpo_pulse_if.sv
// FPro slot bus bundle: select, strobes, address and data for one MMIO slot.
// The master drives the request side and the slave returns combinational read data.
interface gpo_pulse_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/gpo_pulse.sv
// General-purpose output slot: output latch with set/clear/toggle writes,
// readback, and a one-shot engine that inverts a masked group for len cycles.
//
// state     | meaning
// ST_IDLE   | no pulse running, busy=0, dout = buf
// ST_ACTIVE | pulse running, busy=1, dout = buf ^ mask, cnt counts down to 1
module gpo_pulse #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  gpo_pulse_if.slave    bus,
  output logic [W-1:0]  dout
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [4:0] A_DATA  = 5'd0;
  localparam logic [4:0] A_SET   = 5'd1;
  localparam logic [4:0] A_CLR   = 5'd2;
  localparam logic [4:0] A_TGL   = 5'd3;
  localparam logic [4:0] A_PLEN  = 5'd4;
  localparam logic [4:0] A_PULSE = 5'd5;
  localparam logic [4:0] A_STAT  = 5'd6;
  localparam logic [4:0] A_DOUT  = 5'd7;

  logic [W-1:0]     obuf_q, obuf_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [W-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;

  logic             wr_en, rd_en, pulse_wr, stat_wr, busy;
  logic [W-1:0]     wdat;
  logic [31:0]      obuf_ext, len_ext, mask_ext, dout_ext;
  logic             unused_wr;

  assign wr_en     = bus.cs && bus.write;
  assign rd_en     = bus.cs && bus.read;
  assign wdat      = bus.wr_data[W-1:0];
  assign pulse_wr  = wr_en && (bus.addr == A_PULSE);
  assign stat_wr   = wr_en && (bus.addr == A_STAT);
  assign busy      = (state_q == ST_ACTIVE);
  assign unused_wr = ^bus.wr_data;

  assign dout = obuf_q ^ (busy ? mask_q : '0);

  always_comb begin
    obuf_d = obuf_q;
    len_d  = len_q;
    if (wr_en) begin
      case (bus.addr)
        A_DATA:  obuf_d = wdat;
        A_SET:   obuf_d = obuf_q | wdat;
        A_CLR:   obuf_d = obuf_q & ~wdat;
        A_TGL:   obuf_d = obuf_q ^ wdat;
        A_PLEN:  len_d  = bus.wr_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // A PULSE write outranks completion so an aborted pulse never reports done;
  // completion outranks a STAT clear so done cannot be lost.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    done_d  = stat_wr ? 1'b0 : done_q;
    case (state_q)
      ST_IDLE: begin
        if (pulse_wr) begin
          mask_d = wdat;
          if (len_q != '0) begin
            cnt_d   = len_q;
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        if (pulse_wr) begin
          mask_d = wdat;
          cnt_d  = len_q;
          if (len_q == '0) state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      obuf_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      obuf_q  <= obuf_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    obuf_ext = '0;
    len_ext  = '0;
    mask_ext = '0;
    dout_ext = '0;
    obuf_ext[W-1:0]     = obuf_q;
    len_ext[CNT_W-1:0]  = len_q;
    mask_ext[W-1:0]     = mask_q;
    dout_ext[W-1:0]     = dout;
    bus.rd_data = '0;
    if (rd_en) begin
      case (bus.addr)
        A_DATA, A_SET, A_CLR, A_TGL: bus.rd_data = obuf_ext;
        A_PLEN:  bus.rd_data = len_ext;
        A_PULSE: bus.rd_data = mask_ext;
        A_STAT:  bus.rd_data = {30'd0, done_q, busy};
        A_DOUT:  bus.rd_data = dout_ext;
        default: bus.rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpo_pulse.sv
// Directed bench for gpo_pulse: the driver queues expected observations and a
// negedge monitor pops and compares them against dout or rd_data.
module tb_gpo_pulse;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] dout;
  logic       chk_vld = 1'b0;

  typedef struct {
    int          kind;   // 0: dout, 1/2: rd_data
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  gpo_pulse_if bus_if ();

  gpo_pulse #(.W(8), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_vld) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: observation with no expected entry");
      end else begin
        exp_t        e;
        logic [31:0] act;
        e   = sb.pop_front();
        act = (e.kind == 0) ? {24'd0, dout} : bus_if.rd_data;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s actual=%h required=%h", e.tag, act, e.exp);
        end
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_if.cs = 1'b1; bus_if.write = 1'b1; bus_if.addr = a; bus_if.wr_data = d;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.write = 1'b0; bus_if.wr_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input int kind, input logic [4:0] a, input logic [31:0] x, input string tag);
    exp_t e;
    e.kind = kind; e.exp = x; e.tag = tag;
    sb.push_back(e);
    if (kind == 1) begin bus_if.cs = 1'b1; bus_if.read = 1'b1; bus_if.addr = a; end
    else if (kind == 2) begin bus_if.cs = 1'b1; bus_if.read = 1'b0; bus_if.addr = a; end
    chk_vld = 1'b1;
    @(posedge clk); #1;
    chk_vld = 1'b0; bus_if.cs = 1'b0; bus_if.read = 1'b0;
  endtask

  task automatic chk_dout(input logic [7:0] x, input string tag);
    chk(0, 5'd0, {24'd0, x}, tag);
  endtask

  task automatic chk_rd(input logic [4:0] a, input logic [31:0] x, input string tag);
    chk(1, a, x, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.cs = 1'b0; bus_if.read = 1'b0; bus_if.write = 1'b0;
    bus_if.addr = '0; bus_if.wr_data = '0;

    @(posedge clk); #1;
    chk_dout(8'h00, "rst_dout");
    reset_n = 1'b1;
    chk_rd(5'd6, 32'h0, "rst_stat");
    chk_rd(5'd4, 32'h0, "rst_plen");
    chk_rd(5'd5, 32'h0, "rst_mask");

    wr(5'd0, 32'h0000_00A5);
    chk_dout(8'hA5, "data_dout");
    chk_rd(5'd0, 32'hA5, "data_rd0");
    chk_rd(5'd7, 32'hA5, "data_rd7");
    chk(2, 5'd0, 32'h0, "rd_no_strobe");

    wr(5'd1, 32'h0F);
    chk_dout(8'hAF, "set");
    wr(5'd2, 32'hA0);
    chk_dout(8'h0F, "clr");
    wr(5'd3, 32'hFF);
    chk_dout(8'hF0, "tgl");
    wr(5'd1, 32'hFFFF_FF00);
    chk_rd(5'd1, 32'hF0, "set_upper_ignored");
    wr(5'd0, 32'h1234_5623);
    chk_rd(5'd0, 32'h23, "data_upper_ignored");

    // basic 5-cycle pulse
    wr(5'd4, 32'd5);
    chk_rd(5'd4, 32'd5, "plen_rd");
    wr(5'd0, 32'h00);
    wr(5'd5, 32'h03);
    chk_rd(5'd7, 32'h03, "pulse_c0");
    chk_rd(5'd6, 32'h01, "pulse_busy");
    chk_dout(8'h03, "pulse_c2");
    chk_dout(8'h03, "pulse_c3");
    chk_dout(8'h03, "pulse_c4");
    chk_dout(8'h00, "pulse_end");
    chk_rd(5'd6, 32'h02, "pulse_done");
    chk_rd(5'd5, 32'h03, "pulse_mask_rd");
    wr(5'd6, 32'h0);
    chk_rd(5'd6, 32'h00, "stat_clear");

    // retrigger
    wr(5'd4, 32'd10);
    wr(5'd5, 32'h01);
    for (int i = 0; i < 4; i++) chk_dout(8'h01, "retrig_first");
    wr(5'd4, 32'd3);
    wr(5'd5, 32'h80);
    chk_rd(5'd7, 32'h80, "retrig_c0");
    chk_rd(5'd6, 32'h01, "retrig_no_done");
    chk_dout(8'h80, "retrig_c2");
    chk_dout(8'h00, "retrig_end");
    chk_rd(5'd6, 32'h02, "retrig_done");
    wr(5'd6, 32'h0);

    // zero length pulse loads mask only
    wr(5'd4, 32'd0);
    wr(5'd5, 32'hFF);
    chk_dout(8'h00, "zero_len_dout");
    chk_rd(5'd6, 32'h00, "zero_len_stat");
    chk_rd(5'd5, 32'hFF, "zero_len_mask");

    // single-cycle pulse
    wr(5'd4, 32'd1);
    wr(5'd5, 32'h10);
    chk_dout(8'h10, "len1_c0");
    chk_dout(8'h00, "len1_end");
    chk_rd(5'd6, 32'h02, "len1_done");
    wr(5'd6, 32'h0);

    // STAT write lands on the completion edge
    wr(5'd4, 32'd2);
    wr(5'd5, 32'h01);
    chk_dout(8'h01, "race_c0");
    wr(5'd6, 32'h0);
    chk_rd(5'd6, 32'h02, "race_done_wins");
    wr(5'd6, 32'h0);
    chk_rd(5'd6, 32'h00, "race_clear");

    // buf writes and PLEN writes during a pulse
    wr(5'd4, 32'd4);
    wr(5'd5, 32'h0F);
    wr(5'd1, 32'hF0);
    chk_dout(8'hFF, "mid_set");
    wr(5'd4, 32'd100);
    chk_dout(8'hFF, "mid_plen");
    chk_dout(8'hF0, "mid_end");
    wr(5'd6, 32'h0);
    chk_rd(5'd4, 32'd100, "mid_plen_rd");

    // unmapped addresses
    wr(5'd0, 32'h3C);
    wr(5'd8, 32'hFF);
    wr(5'd17, 32'h00);
    wr(5'd31, 32'hFF);
    chk_rd(5'd0, 32'h3C, "unmapped_wr");
    chk_dout(8'h3C, "unmapped_dout");
    for (int a = 8; a < 32; a++) chk_rd(5'(a), 32'h0, "unmapped_rd");

    // reset mid-pulse
    wr(5'd0, 32'h5A);
    wr(5'd4, 32'd20);
    wr(5'd5, 32'h0F);
    chk_dout(8'h55, "pre_rst_pulse");
    reset_n = 1'b0;
    chk_dout(8'h00, "rst_mid_dout");
    reset_n = 1'b1;
    chk_rd(5'd6, 32'h00, "post_rst_stat");
    chk_rd(5'd0, 32'h00, "post_rst_buf");
    chk_rd(5'd4, 32'h00, "post_rst_plen");
    idle(3);
    chk_dout(8'h00, "post_rst_dout");

    idle(2);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: actual=%0d left required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
